hazard_stall_ctrl: RTL and testbench

- Stall and flush controller for the 5-stage pipeline. It is the counterpart of the forwarding logic: it covers the hazards that forwarding cannot resolve.
  - Load-use: inserts one bubble.
  - Taken branch: flushes IF/ID and ID/EX.
  - Data-memory wait: freezes the whole pipeline until `dmem_ready`, with a timeout watchdog.
- Drives the write-enables and bubble/flush controls of the PC and the pipeline registers.

---
 rtl/hazard_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubble, taken-branch flush,
// data-memory wait freeze with watchdog. Optional stall counter under HAZARD_PERF_CNT_EN.
module hazard_stall_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  IF_ID_RegisterRs1,
    input  logic [4:0]  IF_ID_RegisterRs2,
    input  logic        IF_ID_UsesRs2,
    input  logic        ID_EX_MemRead,
    input  logic [4:0]  ID_EX_RegisterRd,
    input  logic        branch_taken,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        PCWrite,
    output logic        IF_ID_Write,
    output logic        IF_ID_Flush,
    output logic        ID_EX_Bubble,
    output logic        pipe_freeze,
    output logic        mem_timeout,
    output logic [31:0] perf_stall_cnt
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             timeout_q, timeout_d;
    logic             mem_hold_s;
    logic             load_use_s;

    // Hazard detection terms; the last MEM_WAIT count releases the freeze
    always_comb begin
        mem_hold_s = ((state_q == RUN) && dmem_req && !dmem_ready) ||
                     ((state_q == MEM_WAIT) && !dmem_ready && (wait_cnt_q != LAST_CNT));
        load_use_s = ID_EX_MemRead && (ID_EX_RegisterRd != 5'd0) &&
                     ((ID_EX_RegisterRd == IF_ID_RegisterRs1) ||
                      (IF_ID_UsesRs2 && (ID_EX_RegisterRd == IF_ID_RegisterRs2)));
    end

    // Pipeline control outputs, priority mem_hold > branch > load-use
    always_comb begin
        PCWrite      = 1'b1;
        IF_ID_Write  = 1'b1;
        IF_ID_Flush  = 1'b0;
        ID_EX_Bubble = 1'b0;
        pipe_freeze  = 1'b0;
        if (mem_hold_s) begin
            PCWrite     = 1'b0;
            IF_ID_Write = 1'b0;
            pipe_freeze = 1'b1;
        end else if (branch_taken) begin
            IF_ID_Flush  = 1'b1;
            ID_EX_Bubble = 1'b1;
        end else if (load_use_s) begin
            PCWrite      = 1'b0;
            IF_ID_Write  = 1'b0;
            ID_EX_Bubble = 1'b1;
        end else begin
            PCWrite     = 1'b1;
            IF_ID_Write = 1'b1;
        end
    end

    // Next-state logic for the memory-wait FSM and watchdog
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        case (state_q)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    state_d    = MEM_WAIT;
                    wait_cnt_d = ONE_CNT;
                end else begin
                    wait_cnt_d = '0;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == LAST_CNT) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    timeout_d  = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + ONE_CNT;
                end
            end
            default: begin
                state_d    = RUN;
                wait_cnt_d = '0;
            end
        endcase
    end

    // FSM state, wait counter and sticky timeout flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign mem_timeout = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_q;

    // Stall-cycle counter, wraps naturally at 32 bits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_q <= 32'h0;
        end else if (!PCWrite) begin
            perf_q <= perf_q + 32'd1;
        end else begin
            perf_q <= perf_q;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed, table-driven bench for hazard_stall_ctrl plus hand-written wait/timeout/reset sequences.
module tb_hazard_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rs1, rs2, rd;
    logic        uses_rs2, memread, br, req, rdy;
    logic        pcw, ifw, flush, bubble, freeze, mto;
    logic [31:0] perf;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] exp_perf = 32'd0;
    logic        exp_to   = 1'b0;
    logic        perf_en;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk(clk), .reset(reset),
        .IF_ID_RegisterRs1(rs1), .IF_ID_RegisterRs2(rs2), .IF_ID_UsesRs2(uses_rs2),
        .ID_EX_MemRead(memread), .ID_EX_RegisterRd(rd),
        .branch_taken(br), .dmem_req(req), .dmem_ready(rdy),
        .PCWrite(pcw), .IF_ID_Write(ifw), .IF_ID_Flush(flush),
        .ID_EX_Bubble(bubble), .pipe_freeze(freeze),
        .mem_timeout(mto), .perf_stall_cnt(perf)
    );

    // expected control word order: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, pipe_freeze}
    typedef struct {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses;
        logic       memread;
        logic [4:0] rd;
        logic       br;
        logic       req;
        logic       rdy;
        logic [4:0] exp;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] a, input logic [4:0] b, input logic u, input logic m,
                          input logic [4:0] d, input logic bt, input logic rq, input logic ry);
        rs1 = a; rs2 = b; uses_rs2 = u; memread = m; rd = d; br = bt; req = rq; rdy = ry;
    endtask

    // one clock: check at negedge, then advance past the posedge and update the counter model
    task automatic step(input string nm, input logic [4:0] exp);
        @(negedge clk);
        chk(nm, {27'd0, pcw, ifw, flush, bubble, freeze}, {27'd0, exp});
        chk({nm, "_to"}, {31'd0, mto}, {31'd0, exp_to});
        chk({nm, "_perf"}, perf, exp_perf);
        @(posedge clk);
        #1;
        if (perf_en && !exp[4]) exp_perf = exp_perf + 32'd1;
    endtask

    initial begin
`ifdef HAZARD_PERF_CNT_EN
        perf_en = 1'b1;
`else
        perf_en = 1'b0;
`endif
        vecs[0] = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[1] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00010};
        vecs[2] = '{5'd5, 5'd3, 1'b0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[3] = '{5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[4] = '{5'd3, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[5] = '{5'd3, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 5'b00010};
        vecs[6] = '{5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 5'b11110};
        vecs[7] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 5'b11110};
        vecs[8] = '{5'd1, 5'd2, 1'b1, 1'b0, 5'd7, 1'b0, 1'b1, 1'b1, 5'b11000};
        vecs[9] = '{5'd9, 5'd9, 1'b1, 1'b1, 5'd9, 1'b0, 1'b1, 1'b1, 5'b00010};

        reset = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("reset_ctrl", {27'd0, pcw, ifw, flush, bubble, freeze}, {27'd0, 5'b11000});
        chk("reset_to", {31'd0, mto}, 32'd0);
        chk("reset_perf", perf, 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            set_in(vecs[i].rs1, vecs[i].rs2, vecs[i].uses, vecs[i].memread,
                   vecs[i].rd, vecs[i].br, vecs[i].req, vecs[i].rdy);
            step($sformatf("vec%0d", i), vecs[i].exp);
        end

        // load-use stalls for exactly one cycle: the load then leaves EX and a bubble follows
        set_in(5'd5, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
        step("lu_stall", 5'b00010);
        set_in(5'd5, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("lu_after", 5'b11000);

        // three-cycle memory wait with a branch pending in EX
        for (int k = 0; k < 3; k++) begin
            set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
            step($sformatf("mw_freeze%0d", k), 5'b00001);
        end
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b1, 1'b1);
        step("mw_ready_branch", 5'b11110);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("mw_back_run", 5'b11000);

        // back-to-back requests get independent waits
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("b2b_a_wait", 5'b00001);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("b2b_a_done", 5'b11000);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("b2b_b_wait0", 5'b00001);
        step("b2b_b_wait1", 5'b00001);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("b2b_b_done", 5'b11000);

        // watchdog: the wait count reaches 15 after 15 frozen cycles, and that cycle is released
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 15; k++) begin
            step($sformatf("to_freeze%0d", k), 5'b00001);
        end
        step("to_release", 5'b11000);
        exp_to = 1'b1;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("to_sticky0", 5'b11000);
        step("to_sticky1", 5'b11000);

        // second wait, aborted by asynchronous reset between clock edges
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("rst_wait0", 5'b00001);
        step("rst_wait1", 5'b00001);
        #2;
        reset = 1'b1;
        req   = 1'b0;
        #1;
        chk("rst_async_ctrl", {27'd0, pcw, ifw, flush, bubble, freeze}, {27'd0, 5'b11000});
        chk("rst_async_to", {31'd0, mto}, 32'd0);
        chk("rst_async_perf", perf, 32'd0);
        exp_to   = 1'b0;
        exp_perf = 32'd0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        step("rst_run_idle", 5'b11000);

        // one load-use stall plus a 3-cycle wait after reset
        set_in(5'd4, 5'd0, 1'b0, 1'b1, 5'd4, 1'b0, 1'b0, 1'b0);
        step("perf_lu", 5'b00010);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        step("perf_w0", 5'b00001);
        step("perf_w1", 5'b00001);
        step("perf_w2", 5'b00001);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);
        step("perf_done", 5'b11000);
        chk("perf_total", perf, perf_en ? 32'd4 : 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
